// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry result buffer per requester.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_zero,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_zero,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic [CNT_WIDTH-1:0]  grant0_cnt,
  output logic [CNT_WIDTH-1:0]  grant1_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic                  rsp0_zero_q, rsp0_zero_d;
  logic                  rsp1_zero_q, rsp1_zero_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic                  last_q, last_d;

  logic elig0, elig1;
  logic grant0, grant1;

  // A full buffer that drains this cycle can take a new result.
  assign elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      (elig0 & elig1): begin
        grant0 = last_q;
        grant1 = ~last_q;
      end
      (elig0 & ~elig1): grant0 = 1'b1;
      (elig1 & ~elig0): grant1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    unique case (1'b1)
      grant0: begin
        alu_a       = req0_a;
        alu_b       = req0_b;
        alu_control = req0_op;
      end
      grant1: begin
        alu_a       = req1_a;
        alu_b       = req1_b;
        alu_control = req1_op;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    last_d        = last_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
      rsp0_zero_d   = alu_zero;
      cnt0_d        = cnt0_q + CNT_ONE;
      last_d        = 1'b0;
    end else if (rsp0_valid_q & rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
      rsp1_zero_d   = alu_zero;
      cnt1_d        = cnt1_q + CNT_ONE;
      last_d        = 1'b1;
    end else if (rsp1_valid_q & rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      last_q        <= 1'b1;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      last_q        <= last_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign grant0_cnt  = cnt0_q;
  assign grant1_cnt  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU
// and an occupancy/turn-based reference model of the arbiter.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_control;
  logic          alu_zero;
  logic [CW-1:0] grant0_cnt, grant1_cnt;

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    logic [DW-1:0] r;
    case (op)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: r = a << b[4:0];
      6'h02: r = a >> b[4:0];
      6'h03: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_result = alu_f(alu_a, alu_b, alu_control);
    alu_zero   = (alu_result == '0);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each buffer is a queue of at most one entry;
  // the turn flag says which port loses the next tie.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  int unsigned cnt0_m = 0, cnt1_m = 0;
  int          last_m = 1;

  always @(negedge clk) begin
    logic e0, e1, g0, g1;
    logic [DW-1:0] ea, eb, r;
    logic [OW-1:0] eo;
    if (rst) begin
      chk("rst_rsp0_valid", 64'(rsp0_valid), 64'(0));
      chk("rst_rsp1_valid", 64'(rsp1_valid), 64'(0));
      chk("rst_cnt0", 64'(grant0_cnt), 64'(0));
      chk("rst_cnt1", 64'(grant1_cnt), 64'(0));
      q0.delete();
      q1.delete();
      cnt0_m = 0;
      cnt1_m = 0;
      last_m = 1;
    end else begin
      e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
      e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
      g0 = e0 && (!e1 || last_m == 1);
      g1 = e1 && (!e0 || last_m == 0);
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      chk("grant0_cnt", 64'(grant0_cnt), 64'(cnt0_m));
      chk("grant1_cnt", 64'(grant1_cnt), 64'(cnt1_m));
      chk("rsp0_valid", 64'(rsp0_valid), 64'(q0.size() != 0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(q1.size() != 0));
      if (q0.size() != 0) begin
        chk("rsp0_result", 64'(rsp0_result), 64'(q0[0][DW-1:0]));
        chk("rsp0_zero", 64'(rsp0_zero), 64'(q0[0][DW]));
        if (rsp0_ready) void'(q0.pop_front());
      end
      if (q1.size() != 0) begin
        chk("rsp1_result", 64'(rsp1_result), 64'(q1[0][DW-1:0]));
        chk("rsp1_zero", 64'(rsp1_zero), 64'(q1[0][DW]));
        if (rsp1_ready) void'(q1.pop_front());
      end
      ea = g0 ? req0_a : g1 ? req1_a : '0;
      eb = g0 ? req0_b : g1 ? req1_b : '0;
      eo = g0 ? req0_op : g1 ? req1_op : '0;
      chk("alu_a", 64'(alu_a), 64'(ea));
      chk("alu_b", 64'(alu_b), 64'(eb));
      chk("alu_control", 64'(alu_control), 64'(eo));
      if (g0) begin
        r = alu_f(req0_a, req0_b, req0_op);
        q0.push_back({r == '0, r});
        cnt0_m = (cnt0_m + 1) % 65536;
        last_m = 0;
      end
      if (g1) begin
        r = alu_f(req1_a, req1_b, req1_op);
        q1.push_back({r == '0, r});
        cnt1_m = (cnt1_m + 1) % 65536;
        last_m = 1;
      end
    end
  end

  logic [OW-1:0] ops[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                             6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

  task automatic rand_req(output logic [DW-1:0] a, output logic [DW-1:0] b,
                          output logic [OW-1:0] op);
    a  = $urandom;
    b  = ($urandom_range(3) == 0) ? a : DW'($urandom);
    op = ops[$urandom_range(9)];
  endtask

  // Each call covers n cycles; starts and ends 1 time unit after a rising edge.
  task automatic rand_cycles(input int n, input int pv0, input int pv1,
                             input int pr0, input int pr1);
    logic a0, a1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(99) < pv0);
        rand_req(req0_a, req0_b, req0_op);
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(99) < pv1);
        rand_req(req1_a, req1_b, req1_op);
      end
      rsp0_ready = ($urandom_range(99) < pr0);
      rsp1_ready = ($urandom_range(99) < pr1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // single ADD on port 0
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 6'h20;
    rsp0_ready = 1;
    #3;
    chk("add_ready", 64'(req0_ready), 64'(1));
    chk("add_alu_a", 64'(alu_a), 64'(5));
    tick();
    req0_valid = 0;
    #1;
    chk("add_result", 64'(rsp0_result), 64'(12));
    chk("add_zero", 64'(rsp0_zero), 64'(0));
    chk("add_cnt0", 64'(grant0_cnt), 64'(1));
    tick();

    // both ports valid every cycle, alternating grants
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 6'h22;
    req1_valid = 1; req1_a = 3; req1_b = 8; req1_op = 6'h2A;
    rsp1_ready = 1;
    repeat (8) tick();
    chk("alt_cnt0", 64'(grant0_cnt), 64'(5));
    chk("alt_cnt1", 64'(grant1_cnt), 64'(4));

    // stalled consumer on port 0 must not block port 1
    rsp0_ready = 0;
    repeat (6) tick();
    rsp0_ready = 1;
    req0_a = 100; req0_b = 1; req0_op = 6'h22;
    #3;
    chk("unstall_ready0", 64'(req0_ready), 64'(1));
    tick();
    chk("reload_valid0", 64'(rsp0_valid), 64'(1));
    chk("reload_result0", 64'(rsp0_result), 64'(99));
    req0_valid = 0; req1_valid = 0;
    tick();

    rand_cycles(800, 70, 70, 70, 70);
    rand_cycles(300, 90, 90, 20, 90);
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) tick();

    // drive port 1 until its counter wraps
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 6'h20;
    for (int i = 0; i < 70000 && cnt1_m != 65535; i++) tick();
    chk("cnt1_full", 64'(grant1_cnt), 64'(16'hFFFF));
    tick();
    chk("cnt1_wrap", 64'(grant1_cnt), 64'(0));
    req1_valid = 0;
    tick();

    // async reset with a full port-1 buffer while port 0 is granted
    req1_valid = 1; req1_a = 1; req1_b = 1; rsp1_ready = 0;
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 6'h20;
    #1;
    chk("pre_rst_rsp1", 64'(rsp1_valid), 64'(1));
    chk("pre_rst_grant0", 64'(req0_ready), 64'(1));
    rst = 1;
    #1;
    chk("async_rsp1", 64'(rsp1_valid), 64'(0));
    tick();
    tick();
    req0_valid = 0;
    rst = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) tick();
    chk("no_rsp0_after_rst", 64'(rsp0_valid), 64'(0));
    req0_valid = 1; req1_valid = 1;
    req0_a = 4; req0_b = 4; req0_op = 6'h26;
    req1_a = 4; req1_b = 1; req1_op = 6'h00;
    #3;
    chk("tie_ready0", 64'(req0_ready), 64'(1));
    chk("tie_ready1", 64'(req1_ready), 64'(0));
    tick();

    rand_cycles(400, 60, 60, 60, 60);
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (4) tick();
    chk("drained0", 64'(q0.size()), 64'(0));
    chk("drained1", 64'(q1.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
